// File: rtl/datapath_seq.sv
// datapath_seq: multi-cycle Moore sequencer driving regfile/ALU strobes.
// Optional retired-instruction counter: DATAPATH_SEQ_RETIRE_CNT_EN.
module datapath_seq #(
    parameter int IMM_SEXT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] instr,
    input  logic        s,
    output logic        w,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] imm_out
`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0] retired
`endif
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WR_IMM,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_REG
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_ir;
    logic        r_err;

    logic [2:0]  w_opc;
    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_sh;
    logic [2:0]  w_rm;
    logic        w_movi;
    logic        w_movr;
    logic        w_mvn;
    logic        w_alu3;
    logic        w_cmp;
    logic        w_legal;

    assign w_opc = r_ir[15:13];
    assign w_op  = r_ir[12:11];
    assign w_rn  = r_ir[10:8];
    assign w_rd  = r_ir[7:5];
    assign w_sh  = r_ir[4:3];
    assign w_rm  = r_ir[2:0];

    assign w_movi  = (w_opc == 3'b110) && (w_op == 2'b10);
    assign w_movr  = (w_opc == 3'b110) && (w_op == 2'b00);
    assign w_mvn   = (w_opc == 3'b101) && (w_op == 2'b11);
    assign w_alu3  = (w_opc == 3'b101) && (w_op != 2'b11);
    assign w_cmp   = (w_opc == 3'b101) && (w_op == 2'b01);
    assign w_legal = w_movi || w_movr || w_mvn || w_alu3;

    // imm8 extension is purely combinational from IR
    assign imm_out = (IMM_SEXT != 0) ? {{8{r_ir[7]}}, r_ir[7:0]}
                                     : {8'h00, r_ir[7:0]};

    assign err = r_err;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    // IR captures only while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir <= 16'h0000;
        end else if (load && (r_state == S_WAIT)) begin
            r_ir <= instr;
        end
    end

    // Sticky illegal flag, cleared by a new start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if ((r_state == S_WAIT) && s) begin
            r_err <= 1'b0;
        end else if ((r_state == S_DECODE) && !w_legal) begin
            r_err <= 1'b1;
        end
    end

    // Next state and Moore strobes
    always_comb begin
        w_next   = r_state;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        unique case (r_state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    w_movi:          w_next = S_WR_IMM;
                    w_movr || w_mvn: w_next = S_GET_B;
                    w_alu3:          w_next = S_GET_A;
                    default:         w_next = S_WAIT;
                endcase
            end
            S_WR_IMM: begin
                writenum = w_rn;
                vsel     = 1'b1;
                write    = 1'b1;
                w_next   = S_WAIT;
            end
            S_GET_A: begin
                readnum = w_rn;
                loada   = 1'b1;
                w_next  = S_GET_B;
            end
            S_GET_B: begin
                readnum = w_rm;
                loadb   = 1'b1;
                w_next  = S_EXEC;
            end
            S_EXEC: begin
                shift = w_sh;
                asel  = w_movr || w_mvn;
                ALUop = w_movr ? 2'b00 : w_op;
                if (w_cmp) begin
                    loads  = 1'b1;
                    w_next = S_WAIT;
                end else begin
                    loadc  = 1'b1;
                    w_next = S_WR_REG;
                end
            end
            S_WR_REG: begin
                writenum = w_rd;
                write    = 1'b1;
                w_next   = S_WAIT;
            end
            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

`ifdef DATAPATH_SEQ_RETIRE_CNT_EN
    logic w_retire;

    // Retire = return to idle from any completing state
    assign w_retire = (w_next == S_WAIT) &&
                      (r_state != S_WAIT) &&
                      (r_state != S_DECODE);

    // Wrapping count of completed instructions
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired <= 16'h0000;
        end else if (w_retire) begin
            retired <= retired + 16'h0001;
        end
    end
`else
`endif

endmodule
